// File: rtl/seq_detect_prog.sv
`default_nettype none
// ============================================================================
//  Module      : seq_detect_prog
//  Description : Runtime-programmable serial bit-pattern detector. Pattern,
//                length (1..MAX_LEN) and overlap mode are loaded with
//                cfg_load. A registered one-cycle match pulse is raised for
//                every match, and match_count counts matches and saturates.
//                Optional build macro SEQ_DET_MASK_EN adds a per-bit
//                don't-care mask input (cfg_mask) captured on cfg_load.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_detect_prog #(
    parameter int MAX_LEN = 16,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
`ifdef SEQ_DET_MASK_EN
    input  logic [MAX_LEN-1:0] cfg_mask,
`endif
    input  logic               cnt_clr,
    input  logic               bit_valid,
    input  logic               bit_in,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    output logic               armed,
    output logic               cfg_err
);

    localparam logic [0:0]       c_st_idle = 1'b0;
    localparam logic [0:0]       c_st_run  = 1'b1;
    localparam logic [LEN_W-1:0] c_max_len = LEN_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    logic [0:0]         r_state;
    logic [0:0]         w_state_next;

    // Only MAX_LEN-1 past bits are kept: together with the incoming bit they
    // form the full MAX_LEN window that is compared.
    logic [MAX_LEN-2:0] r_hist;
    logic [LEN_W-1:0]   r_fill;
    logic [MAX_LEN-1:0] r_pattern;
    logic [LEN_W-1:0]   r_len;
    logic               r_overlap;
    logic               r_match;
    logic               r_cfg_err;
    logic [CNT_W-1:0]   r_count;

    logic               w_len_ok;
    logic               w_accept;
    logic               w_reject;
    logic               w_shift;
    logic [MAX_LEN-1:0] w_hist_next;
    logic [LEN_W-1:0]   w_fill_next;
    logic [MAX_LEN-1:0] w_len_mask;
    logic [MAX_LEN-1:0] w_dont_care;
    logic               w_hit;

    // Configuration qualification; cfg_load always takes priority over data.
    assign w_len_ok    = (cfg_len != '0) && (cfg_len <= c_max_len);
    assign w_accept    = cfg_load & w_len_ok;
    assign w_reject    = cfg_load & ~w_len_ok;
    assign w_shift     = (r_state == c_st_run) & bit_valid & ~cfg_load;

    // The window including the bit arriving this cycle is what gets compared.
    assign w_hist_next = {r_hist, bit_in};
    assign w_fill_next = (r_fill == c_max_len) ? r_fill : r_fill + LEN_W'(1);

    // Build a mask selecting the low r_len bits of the window.
    always_comb begin
        w_len_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_len_mask[i] = (i < int'(r_len));
        end
    end

`ifdef SEQ_DET_MASK_EN
    logic [MAX_LEN-1:0] r_mask;

    // Capture the don't-care mask together with the rest of the configuration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mask <= '0;
        end else if (w_accept) begin
            r_mask <= cfg_mask;
        end else if (w_reject) begin
            r_mask <= '0;
        end
    end

    assign w_dont_care = r_mask;
`else
    assign w_dont_care = '0;
`endif

    // A hit needs enough history and agreement on every cared-about bit.
    assign w_hit = w_shift && (w_fill_next >= r_len) &&
                   (((w_hist_next ^ r_pattern) & w_len_mask & ~w_dont_care) == '0);

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: legal load arms (or re-arms), illegal load disarms.
    always_comb begin
        w_state_next = r_state;
        if (w_accept) begin
            w_state_next = c_st_run;
        end else if (w_reject) begin
            w_state_next = c_st_idle;
        end
    end

    // FSM outputs.
    always_comb begin
        armed = (r_state == c_st_run);
    end

    // Configuration registers; a rejected load discards the old setup.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pattern <= '0;
            r_len     <= '0;
            r_overlap <= 1'b0;
        end else if (w_accept) begin
            r_pattern <= cfg_pattern;
            r_len     <= cfg_len;
            r_overlap <= cfg_overlap;
        end else if (w_reject) begin
            r_pattern <= '0;
            r_len     <= '0;
            r_overlap <= 1'b0;
        end
    end

    // History shift and fill tracking; non-overlap mode restarts fill on a hit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (cfg_load) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (w_shift) begin
            r_hist <= w_hist_next[MAX_LEN-2:0];
            r_fill <= (w_hit && !r_overlap) ? '0 : w_fill_next;
        end
    end

    // Registered match and configuration-error pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_match   <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_match   <= w_hit;
            r_cfg_err <= w_reject;
        end
    end

    // Saturating match counter; a clear coinciding with a hit leaves one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (cnt_clr) begin
            r_count <= w_hit ? CNT_W'(1) : '0;
        end else if (w_hit && (r_count != c_cnt_max)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign match       = r_match;
    assign match_count = r_count;
    assign cfg_err     = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_prog.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_detect_prog
//  Description : Self-checking bench for seq_detect_prog. Two instances share
//                all inputs: the default build and one with CNT_W=2 to
//                exercise counter saturation. A queue-based reference model
//                tracks the received bits and decides matches directly from
//                the pattern definition.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_detect_prog;

    localparam int MAX_LEN = 16;
    localparam int LEN_W   = 5;
`ifdef SEQ_DET_MASK_EN
    localparam bit MASK_ON = 1'b1;
`else
    localparam bit MASK_ON = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               cfg_load = 1'b0;
    logic [MAX_LEN-1:0] cfg_pattern = '0;
    logic [LEN_W-1:0]   cfg_len = '0;
    logic               cfg_overlap = 1'b0;
    logic [MAX_LEN-1:0] cfg_mask = '0;
    logic               cnt_clr = 1'b0;
    logic               bit_valid = 1'b0;
    logic               bit_in = 1'b0;
    logic               match, match2;
    logic [7:0]         match_count;
    logic [1:0]         match_count2;
    logic               armed, armed2;
    logic               cfg_err, cfg_err2;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit                 m_armed;
    int                 m_len;
    logic [MAX_LEN-1:0] m_pat;
    logic [MAX_LEN-1:0] m_mask;
    bit                 m_ovl;
    bit                 m_q[$];
    bit                 m_match;
    bit                 m_err;
    int                 m_cnt;
    int                 m_cnt2;

    seq_detect_prog #(.MAX_LEN(MAX_LEN), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
`ifdef SEQ_DET_MASK_EN
        .cfg_mask(cfg_mask),
`endif
        .cnt_clr(cnt_clr), .bit_valid(bit_valid), .bit_in(bit_in),
        .match(match), .match_count(match_count), .armed(armed), .cfg_err(cfg_err)
    );

    seq_detect_prog #(.MAX_LEN(MAX_LEN), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
`ifdef SEQ_DET_MASK_EN
        .cfg_mask(cfg_mask),
`endif
        .cnt_clr(cnt_clr), .bit_valid(bit_valid), .bit_in(bit_in),
        .match(match2), .match_count(match_count2), .armed(armed2), .cfg_err(cfg_err2)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    task automatic model_reset();
        m_armed = 0; m_len = 0; m_pat = '0; m_mask = '0; m_ovl = 0;
        m_q.delete(); m_match = 0; m_err = 0; m_cnt = 0; m_cnt2 = 0;
    endtask

    // Apply one cycle of inputs, advance one clock, then update the model.
    task automatic cycle(input bit ld, input logic [MAX_LEN-1:0] pat, input int len,
                         input bit ovl, input bit clr, input bit bv, input bit bi);
        bit hit;
        cfg_load = ld; cfg_pattern = pat; cfg_len = LEN_W'(len); cfg_overlap = ovl;
        cnt_clr = clr; bit_valid = bv; bit_in = bi;
        @(posedge clk); #1;
        hit = 0;
        if (ld) begin
            m_q.delete();
            if (len >= 1 && len <= MAX_LEN) begin
                m_armed = 1; m_len = len; m_pat = pat; m_ovl = ovl; m_err = 0;
                m_mask = MASK_ON ? cfg_mask : '0;
            end else begin
                m_armed = 0; m_len = 0; m_pat = '0; m_mask = '0; m_ovl = 0; m_err = 1;
            end
        end else begin
            m_err = 0;
            if (m_armed && bv) begin
                m_q.push_back(bi);
                if (m_q.size() > MAX_LEN) void'(m_q.pop_front());
                if (m_q.size() >= m_len) begin
                    hit = 1;
                    // k-th bit in arrival order must equal pattern bit len-1-k
                    for (int k = 0; k < m_len; k++) begin
                        int idx;
                        idx = m_q.size() - m_len + k;
                        if (!m_mask[m_len-1-k] && (m_q[idx] != m_pat[m_len-1-k])) hit = 0;
                    end
                end
                if (hit && !m_ovl) m_q.delete();
            end
        end
        m_match = hit;
        if (clr) begin
            m_cnt  = hit ? 1 : 0;
            m_cnt2 = hit ? 1 : 0;
        end else if (hit) begin
            if (m_cnt < 255) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
        end
        cfg_load = 0; cnt_clr = 0; bit_valid = 0;
    endtask

    task automatic send_bit(input bit b);
        cycle(0, cfg_pattern, int'(cfg_len), cfg_overlap, 0, 1, b);
    endtask

    task automatic idle();
        cycle(0, cfg_pattern, int'(cfg_len), cfg_overlap, 0, 0, 0);
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (match !== 1'b0) begin failures++; $display("FAIL reset_match got=%b exp=0", match); end
        checks++; if (match_count !== 8'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", match_count); end
        checks++; if (armed !== 1'b0) begin failures++; $display("FAIL reset_armed got=%b exp=0", armed); end
        checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL reset_cfg_err got=%b exp=0", cfg_err); end
        checks++; if (match_count2 !== 2'd0) begin failures++; $display("FAIL reset_count2 got=%0d exp=0", match_count2); end
        rst = 0;
        model_reset();
    endtask

    // 7-bit non-overlap pattern with random idle gaps between valid bits.
    task automatic test_fixed7();
        logic [7:0] s;
        int pulses;
        s = 8'b0110_1100;
        pulses = 0;
        cycle(1, 16'b110_1100, 7, 0, 1, 0, 0);
        checks++; if (armed !== 1'b1) begin failures++; $display("FAIL fixed7_armed got=%b exp=1", armed); end
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 2)) begin
                idle();
                pulses += int'(match);
                checks++; if (match !== 1'b0) begin failures++; $display("FAIL fixed7_gap bit=%0d got=%b exp=0", i, match); end
            end
            send_bit(s[7-i]);
            pulses += int'(match);
            checks++; if (match !== (i == 7)) begin failures++; $display("FAIL fixed7_match bit=%0d got=%b exp=%b", i, match, (i == 7)); end
        end
        idle();
        pulses += int'(match);
        checks++; if (pulses != 1) begin failures++; $display("FAIL fixed7_pulses got=%0d exp=1", pulses); end
        checks++; if (match_count !== 8'd1) begin failures++; $display("FAIL fixed7_count got=%0d exp=1", match_count); end
    endtask

    // 1011 on stream 1011011 in both overlap modes.
    task automatic test_overlap();
        logic [6:0] s;
        logic [6:0] exp_m;
        s = 7'b1011011;
        for (int mode = 1; mode >= 0; mode--) begin
            exp_m = (mode == 1) ? 7'b0001001 : 7'b0001000;
            cycle(1, 16'b1011, 4, bit'(mode), 1, 0, 0);
            for (int i = 0; i < 7; i++) begin
                send_bit(s[6-i]);
                checks++; if (match !== exp_m[6-i]) begin failures++; $display("FAIL overlap%0d_match bit=%0d got=%b exp=%b", mode, i + 1, match, exp_m[6-i]); end
            end
            checks++; if (match_count !== ((mode == 1) ? 8'd2 : 8'd1)) begin failures++; $display("FAIL overlap%0d_count got=%0d exp=%0d", mode, match_count, (mode == 1) ? 2 : 1); end
        end
    endtask

    // Illegal lengths disarm and pulse cfg_err.
    task automatic test_cfg_err();
        cycle(1, 16'hF, 4, 1, 0, 0, 0);
        checks++; if (armed !== 1'b1 || cfg_err !== 1'b0) begin failures++; $display("FAIL cfgerr_legal armed=%b err=%b exp armed=1 err=0", armed, cfg_err); end
        cycle(1, 16'hF, 0, 1, 0, 0, 0);
        checks++; if (cfg_err !== 1'b1 || armed !== 1'b0) begin failures++; $display("FAIL cfgerr_len0 err=%b armed=%b exp err=1 armed=0", cfg_err, armed); end
        idle();
        checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL cfgerr_pulse got=%b exp=0", cfg_err); end
        cycle(1, 16'hF, MAX_LEN + 1, 1, 0, 0, 0);
        checks++; if (cfg_err !== 1'b1 || armed !== 1'b0) begin failures++; $display("FAIL cfgerr_len17 err=%b armed=%b exp err=1 armed=0", cfg_err, armed); end
        for (int i = 0; i < 4; i++) begin
            send_bit(1'b1);
            checks++; if (match !== 1'b0 || armed !== 1'b0) begin failures++; $display("FAIL cfgerr_stream bit=%0d match=%b armed=%b exp 0/0", i, match, armed); end
        end
    endtask

    // cfg_load on the last pattern bit drops the bit and empties the history.
    task automatic test_collision();
        cycle(1, 16'b0001, 4, 1, 0, 0, 0);
        send_bit(0); send_bit(0); send_bit(0);
        cycle(1, 16'b0001, 4, 1, 0, 1, 1);
        checks++; if (match !== 1'b0 || armed !== 1'b1) begin failures++; $display("FAIL collide_load match=%b armed=%b exp 0/1", match, armed); end
        send_bit(1);
        checks++; if (match !== 1'b0) begin failures++; $display("FAIL collide_fill got=%b exp=0", match); end
        send_bit(0); send_bit(0); send_bit(0);
        checks++; if (match !== 1'b0) begin failures++; $display("FAIL collide_early got=%b exp=0", match); end
        send_bit(1);
        checks++; if (match !== 1'b1) begin failures++; $display("FAIL collide_rematch got=%b exp=1", match); end
    endtask

    // Single-bit pattern; every 1 is a match, CNT_W=2 instance saturates at 3.
    task automatic test_saturate();
        cycle(1, 16'h1, 1, 1, 1, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            send_bit(1);
            checks++; if (match_count !== 8'(k)) begin failures++; $display("FAIL sat_count8 k=%0d got=%0d exp=%0d", k, match_count, k); end
            checks++; if (match_count2 !== 2'((k > 3) ? 3 : k)) begin failures++; $display("FAIL sat_count2 k=%0d got=%0d exp=%0d", k, match_count2, (k > 3) ? 3 : k); end
        end
        cycle(0, 16'h1, 1, 1, 1, 1, 1);
        checks++; if (match_count !== 8'd1 || match_count2 !== 2'd1) begin failures++; $display("FAIL sat_clr_hit got=%0d/%0d exp=1/1", match_count, match_count2); end
        cycle(0, 16'h1, 1, 1, 1, 0, 0);
        checks++; if (match_count !== 8'd0 || match_count2 !== 2'd0) begin failures++; $display("FAIL sat_clr got=%0d/%0d exp=0/0", match_count, match_count2); end
    endtask

    // Reset in the middle of operation clears outputs without a clock edge.
    task automatic test_reset_midstream();
        cycle(1, 16'b1011, 4, 1, 0, 0, 0);
        send_bit(1); send_bit(0); send_bit(1); send_bit(1);
        checks++; if (match !== 1'b1) begin failures++; $display("FAIL midrst_pre got=%b exp=1", match); end
        #1 rst = 1;
        #1;
        checks++; if (match !== 1'b0 || match_count !== 8'd0 || armed !== 1'b0 || cfg_err !== 1'b0) begin
            failures++; $display("FAIL midrst_async match=%b count=%0d armed=%b err=%b exp all 0", match, match_count, armed, cfg_err);
        end
        @(posedge clk); #1;
        rst = 0;
        model_reset();
        send_bit(1); send_bit(0); send_bit(1); send_bit(1);
        checks++; if (match !== 1'b0 || armed !== 1'b0) begin failures++; $display("FAIL midrst_idle match=%b armed=%b exp 0/0", match, armed); end
    endtask

`ifdef SEQ_DET_MASK_EN
    task automatic test_mask();
        logic [3:0] streams [2];
        streams[0] = 4'b1111;
        streams[1] = 4'b1001;
        cfg_mask = 16'b0110;
        cycle(1, 16'b1001, 4, 0, 0, 0, 0);
        for (int s = 0; s < 2; s++) begin
            for (int i = 3; i >= 0; i--) begin
                send_bit(streams[s][i]);
                checks++; if (match !== (i == 0)) begin failures++; $display("FAIL mask_s%0d bit=%0d got=%b exp=%b", s, 3 - i, match, (i == 0)); end
            end
        end
        cfg_mask = '0;
    endtask
`endif

    // Random configuration, data and clears against the reference model.
    task automatic test_random();
        int len;
        for (int n = 0; n < 3000; n++) begin
            bit ld;
            ld = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 9) == 0) len = $urandom_range(0, 31);
            else len = $urandom_range(1, 5);
            if (MASK_ON) cfg_mask = MAX_LEN'($urandom);
            cycle(ld, MAX_LEN'($urandom), len, bit'($urandom_range(0, 1)),
                  ($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)));
            checks++; if (match !== m_match) begin failures++; $display("FAIL rand_match n=%0d got=%b exp=%b", n, match, m_match); end
            checks++; if (match_count !== 8'(m_cnt)) begin failures++; $display("FAIL rand_count n=%0d got=%0d exp=%0d", n, match_count, m_cnt); end
            checks++; if (match_count2 !== 2'(m_cnt2)) begin failures++; $display("FAIL rand_count2 n=%0d got=%0d exp=%0d", n, match_count2, m_cnt2); end
            checks++; if (armed !== m_armed || armed2 !== m_armed) begin failures++; $display("FAIL rand_armed n=%0d got=%b/%b exp=%b", n, armed, armed2, m_armed); end
            checks++; if (cfg_err !== m_err || cfg_err2 !== m_err) begin failures++; $display("FAIL rand_cfg_err n=%0d got=%b/%b exp=%b", n, cfg_err, cfg_err2, m_err); end
            checks++; if (match2 !== m_match) begin failures++; $display("FAIL rand_match2 n=%0d got=%b exp=%b", n, match2, m_match); end
        end
    endtask

    initial begin
        test_reset();
        test_fixed7();
        test_overlap();
        test_cfg_err();
        test_collision();
        test_saturate();
        test_reset_midstream();
`ifdef SEQ_DET_MASK_EN
        test_mask();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
